ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_rx_fifo.sv | 275 +++++++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver with a byte FIFO.
// Both bus lines are synchronised and de-glitched. A small FSM assembles
// 11-bit frames: start, 8 data bits LSB first, odd parity, stop. Good bytes
// are queued in a power-of-two FIFO. Sticky flags report dropped bytes,
// parity failures, and framing or timeout failures.
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2  = 3,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [7:0]            data,
    output logic                  ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  parity_err,
    output logic                  frame_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT  = WD_W'(TIMEOUT_CYC);
    localparam logic [3:0]      FLT_LIMIT = 4'(FILTER_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STOP  = 2'd2
    } state_t;

    // Synchroniser and filter state. Everything resets to 1 (idle bus).
    logic clk_meta_q, clk_meta_d;
    logic clk_sync_q, clk_sync_d;
    logic data_meta_q, data_meta_d;
    logic data_sync_q, data_sync_d;
    logic [3:0] clk_cnt_q, clk_cnt_d;
    logic [3:0] data_cnt_q, data_cnt_d;
    logic clk_filt_q, clk_filt_d;
    logic data_filt_q, data_filt_d;
    logic clk_prev_q, clk_prev_d;

    // Receive FSM state.
    state_t          state_q, state_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [8:0]      shift_q, shift_d;
    logic [WD_W-1:0] wd_q, wd_d;

    // FIFO state.
    logic [7:0]          mem_q [DEPTH];
    logic [7:0]          mem_d [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;

    // Sticky error flags.
    logic overflow_q, overflow_d;
    logic parity_err_q, parity_err_d;
    logic frame_err_q, frame_err_d;

    // Internal events.
    logic sample_evt;
    logic sample_bit;
    logic frame_good;
    logic set_perr;
    logic set_ferr;
    logic fifo_empty;
    logic fifo_full;
    logic do_pop;
    logic do_push;
    logic do_drop;

    // Two-flop synchronisers that bring both bus lines into the clk domain.
    always_comb begin
        clk_meta_d  = ps2_clk;
        clk_sync_d  = clk_meta_q;
        data_meta_d = ps2_data;
        data_sync_d = data_meta_q;
    end

    // Clock-line filter: follow the synchronised line only after FILTER_LEN consecutive differing samples.
    always_comb begin
        clk_cnt_d  = '0;
        clk_filt_d = clk_filt_q;
        if (clk_sync_q != clk_filt_q) begin
            if (clk_cnt_q + 4'd1 == FLT_LIMIT) begin
                clk_filt_d = clk_sync_q;
            end else begin
                clk_cnt_d = clk_cnt_q + 4'd1;
            end
        end
    end

    // Data-line filter, identical in behaviour to the clock-line filter.
    always_comb begin
        data_cnt_d  = '0;
        data_filt_d = data_filt_q;
        if (data_sync_q != data_filt_q) begin
            if (data_cnt_q + 4'd1 == FLT_LIMIT) begin
                data_filt_d = data_sync_q;
            end else begin
                data_cnt_d = data_cnt_q + 4'd1;
            end
        end
    end

    // A falling edge of the filtered clock marks the cycle in which the filtered data bit is taken.
    always_comb begin
        clk_prev_d = clk_filt_q;
        sample_evt = clk_prev_q & ~clk_filt_q;
        sample_bit = data_filt_q;
    end

    // Receive FSM: frame assembly, parity and stop checks, and the inactivity watchdog.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        wd_d       = wd_q;
        frame_good = 1'b0;
        set_perr   = 1'b0;
        set_ferr   = 1'b0;
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (sample_evt && !sample_bit) begin
                    state_d   = SHIFT;
                    bit_idx_d = '0;
                end
            end
            SHIFT: begin
                if (sample_evt) begin
                    shift_d = {sample_bit, shift_q[8:1]};
                    wd_d    = '0;
                    if (bit_idx_q == 4'd8) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else if (wd_q + WD_W'(1) == WD_LIMIT) begin
                    set_ferr  = 1'b1;
                    state_d   = IDLE;
                    wd_d      = '0;
                    bit_idx_d = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            STOP: begin
                if (sample_evt) begin
                    state_d   = IDLE;
                    wd_d      = '0;
                    bit_idx_d = '0;
                    if (!sample_bit) begin
                        set_ferr = 1'b1;
                    end else if (^shift_q) begin
                        frame_good = 1'b1;
                    end else begin
                        set_perr = 1'b1;
                    end
                end else if (wd_q + WD_W'(1) == WD_LIMIT) begin
                    set_ferr  = 1'b1;
                    state_d   = IDLE;
                    wd_d      = '0;
                    bit_idx_d = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                wd_d      = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // FIFO control. A simultaneous pop frees the slot that a push into a full FIFO needs.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
        do_pop     = rd_en && !fifo_empty;
        do_push    = frame_good && (!fifo_full || do_pop);
        do_drop    = frame_good && fifo_full && !do_pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = shift_q[7:0];
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Sticky flags: clr_err clears them, and a same-cycle error event takes priority.
    always_comb begin
        overflow_d   = clr_err ? 1'b0 : overflow_q;
        parity_err_d = clr_err ? 1'b0 : parity_err_q;
        frame_err_d  = clr_err ? 1'b0 : frame_err_q;
        if (do_drop) begin
            overflow_d = 1'b1;
        end
        if (set_perr) begin
            parity_err_d = 1'b1;
        end
        if (set_ferr) begin
            frame_err_d = 1'b1;
        end
    end

    // Output view of the FIFO head and occupancy.
    always_comb begin
        data       = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
        ready      = !fifo_empty;
        count      = wr_ptr_q - rd_ptr_q;
        overflow   = overflow_q;
        parity_err = parity_err_q;
        frame_err  = frame_err_q;
    end

    // All control registers, with synchronous reset to an idle bus and an empty FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            data_meta_q  <= 1'b1;
            data_sync_q  <= 1'b1;
            clk_cnt_q    <= '0;
            data_cnt_q   <= '0;
            clk_filt_q   <= 1'b1;
            data_filt_q  <= 1'b1;
            clk_prev_q   <= 1'b1;
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            wd_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_meta_q   <= clk_meta_d;
            clk_sync_q   <= clk_sync_d;
            data_meta_q  <= data_meta_d;
            data_sync_q  <= data_sync_d;
            clk_cnt_q    <= clk_cnt_d;
            data_cnt_q   <= data_cnt_d;
            clk_filt_q   <= clk_filt_d;
            data_filt_q  <= data_filt_d;
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            wd_q         <= wd_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // FIFO storage. Stale contents are harmless because the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed testbench for ps2_rx_fifo: a 4-entry FIFO, a 4-sample filter and a short watchdog.
module tb_ps2_rx_fifo;

    localparam int HALF = 10;
    localparam int TOUT = 300;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] data;
    logic       ready;
    logic [2:0] count;
    logic       overflow;
    logic       parity_err;
    logic       frame_err;

    int   errors = 0;
    int   checks = 0;
    logic readyAtStop;
    logic readyAfterStop;
    logic [2:0] countAfterStop;

    ps2_rx_fifo #(
        .DEPTH_LOG2 (2),
        .FILTER_LEN (4),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .data      (data),
        .ready     (ready),
        .count     (count),
        .overflow  (overflow),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it if the observed value differs from the expected one.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Sends the first nbits bits of a frame. Optionally pulses rd_en or clr_err in the stop-sample cycle.
    task automatic applyStimulus(input logic [7:0] b, input logic par, input logic stop,
                                 input int nbits, input bit popAtStop, input bit clrAtStop);
        logic [10:0] frm;
        int          waited;
        bit          found;
        frm = {stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frm[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                waited = 0;
                found  = 1'b0;
                while (!found && waited < HALF - 2) begin
                    @(negedge clk);
                    waited++;
                    if (dut.sample_evt) found = 1'b1;
                end
                checkOutput("stopSampleSeen", 32'(found), 32'd1);
                readyAtStop = ready;
                rd_en       = popAtStop;
                clr_err     = clrAtStop;
                @(negedge clk);
                waited++;
                rd_en          = 1'b0;
                clr_err        = 1'b0;
                readyAfterStop = ready;
                countAfterStop = count;
                repeat (HALF - waited) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Checks the head byte, then pops it.
    task automatic popAndCheck(input string tag, input logic [7:0] expected);
        checkOutput(tag, 32'(data), 32'(expected));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Pulses clr_err for a single cycle.
    task automatic pulseClear();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // Checks all three sticky flags against the expected values.
    task automatic checkFlags(input string tag, input logic ov, input logic pe, input logic fe);
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'(ov));
        checkOutput({tag, ".parity_err"}, 32'(parity_err), 32'(pe));
        checkOutput({tag, ".frame_err"}, 32'(frame_err), 32'(fe));
    endtask

    initial begin
        int          waitCnt;
        logic [7:0]  b;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_en    = 1'b0;
        clr_err  = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst.ready", 32'(ready), 32'd0);
        checkOutput("rst.count", 32'(count), 32'd0);
        checkFlags("rst", 1'b0, 1'b0, 1'b0);

        $display("[TB] good frame 0x1C");
        applyStimulus(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        checkOutput("f1C.readyAtStop", 32'(readyAtStop), 32'd0);
        checkOutput("f1C.readyAfterStop", 32'(readyAfterStop), 32'd1);
        checkOutput("f1C.countAfterStop", 32'(countAfterStop), 32'd1);
        checkOutput("f1C.count", 32'(count), 32'd1);
        checkFlags("f1C", 1'b0, 1'b0, 1'b0);
        popAndCheck("f1C.data", 8'h1C);
        checkOutput("f1C.readyAfterPop", 32'(ready), 32'd0);

        $display("[TB] bad parity frame 0x1C");
        applyStimulus(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        checkOutput("par.count", 32'(count), 32'd0);
        checkFlags("par", 1'b0, 1'b1, 1'b0);
        pulseClear();
        checkFlags("parClr", 1'b0, 1'b0, 1'b0);

        $display("[TB] pop while empty is ignored");
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checkOutput("emptyPop.count", 32'(count), 32'd0);
        checkOutput("emptyPop.ready", 32'(ready), 32'd0);
        checkFlags("emptyPop", 1'b0, 1'b0, 1'b0);

        $display("[TB] bad stop bit with bad parity");
        applyStimulus(8'h33, 1'b0, 1'b0, 11, 1'b0, 1'b0);
        checkOutput("stop.count", 32'(count), 32'd0);
        checkFlags("stop", 1'b0, 1'b0, 1'b1);
        pulseClear();

        $display("[TB] clear coincides with a parity error");
        applyStimulus(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b1);
        checkFlags("setWins", 1'b0, 1'b1, 1'b0);
        pulseClear();

        $display("[TB] overflow on a 4-deep FIFO");
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            applyStimulus(b, ~^b, 1'b1, 11, 1'b0, 1'b0);
        end
        checkOutput("ovf.count", 32'(count), 32'd4);
        checkFlags("ovf", 1'b1, 1'b0, 1'b0);
        popAndCheck("ovf.pop1", 8'h01);
        popAndCheck("ovf.pop2", 8'h02);
        popAndCheck("ovf.pop3", 8'h03);
        popAndCheck("ovf.pop4", 8'h04);
        checkOutput("ovf.readyEnd", 32'(ready), 32'd0);
        checkOutput("ovf.countEnd", 32'(count), 32'd0);
        checkOutput("ovf.sticky", 32'(overflow), 32'd1);
        pulseClear();

        $display("[TB] push and pop together while full");
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            applyStimulus(b, ~^b, 1'b1, 11, 1'b0, 1'b0);
        end
        checkOutput("pp.countFull", 32'(count), 32'd4);
        applyStimulus(8'h05, 1'b1, 1'b1, 11, 1'b1, 1'b0);
        checkOutput("pp.countAfterStop", 32'(countAfterStop), 32'd4);
        checkOutput("pp.count", 32'(count), 32'd4);
        checkFlags("pp", 1'b0, 1'b0, 1'b0);
        popAndCheck("pp.pop1", 8'h02);
        popAndCheck("pp.pop2", 8'h03);
        popAndCheck("pp.pop3", 8'h04);
        popAndCheck("pp.pop4", 8'h05);
        checkOutput("pp.readyEnd", 32'(ready), 32'd0);

        $display("[TB] watchdog abort of a partial frame");
        applyStimulus(8'hF0, 1'b1, 1'b1, 4, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        checkOutput("tout.early", 32'(frame_err), 32'd0);
        waitCnt = 0;
        while (!frame_err && waitCnt < 2 * TOUT) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("tout.frame_err", 32'(frame_err), 32'd1);
        checkOutput("tout.count", 32'(count), 32'd0);
        pulseClear();
        applyStimulus(8'hF0, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        checkOutput("tout.nextCount", 32'(count), 32'd1);
        checkFlags("tout.next", 1'b0, 1'b0, 1'b0);
        popAndCheck("tout.nextData", 8'hF0);

        $display("[TB] short glitch on ps2_clk");
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("glitch.ready", 32'(ready), 32'd0);
        checkFlags("glitch", 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h5A, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        checkOutput("glitch.count", 32'(count), 32'd1);
        checkOutput("glitch.data", 32'(data), 32'h5A);
        checkFlags("glitch.after", 1'b0, 1'b0, 1'b0);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        checkOutput("mid.preParity", 32'(parity_err), 32'd1);
        applyStimulus(8'hAA, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid.ready", 32'(ready), 32'd0);
        checkOutput("mid.count", 32'(count), 32'd0);
        checkFlags("mid", 1'b0, 1'b0, 1'b0);
        repeat (2 * TOUT) @(negedge clk);
        checkOutput("mid.noTimeout", 32'(frame_err), 32'd0);
        applyStimulus(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        checkOutput("mid.nextCount", 32'(count), 32'd1);
        checkOutput("mid.nextData", 32'(data), 32'h1C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
